// File: rtl/xor_rr_arbiter.sv
// Round-robin arbiter sharing one XOR correction stage among NREQ requesters.
// Define XOR_ARB_PARITY_EN to add the registered out_parity output.
module xor_rr_arbiter #(
    parameter int WIDTH = 11,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_bus,
    input  logic [NREQ*WIDTH-1:0]   b_bus,
    output logic [NREQ-1:0]         grant,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [1:0]              out_id,
`ifdef XOR_ARB_PARITY_EN
    output logic                    out_parity,
`endif
    input  logic                    out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic             can_load;
    logic             found;
    logic [1:0]       win;
    logic [1:0]       nxt_ptr;
    logic [2:0]       idx;
    logic [WIDTH-1:0] result;

    assign out_valid = (state == FULL);

    // Search ptr, ptr+1, ... modulo NREQ; first set request wins.
    always_comb begin
        can_load = (state == EMPTY) || out_ready;
        found    = 1'b0;
        win      = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 3'(ptr) + 3'(k);
            if (idx >= 3'(NREQ))
                idx = idx - 3'(NREQ);
            if (!found && req[idx[1:0]]) begin
                found = 1'b1;
                win   = idx[1:0];
            end
        end
        nxt_ptr = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
        result  = a_bus[win*WIDTH +: WIDTH] ^ b_bus[win*WIDTH +: WIDTH];
        grant   = '0;
        if (!reset && can_load && found)
            grant = NREQ'(1) << win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            out_data <= '0;
            out_id   <= '0;
`ifdef XOR_ARB_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (can_load) begin
            if (found) begin
                state    <= FULL;
                ptr      <= nxt_ptr;
                out_data <= result;
                out_id   <= win;
`ifdef XOR_ARB_PARITY_EN
                out_parity <= ^result;
`endif
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_xor_rr_arbiter.sv
// Bench for xor_rr_arbiter: directed vectors, literal checks and a
// per-cycle comparison against a behavioural model.
module tb_xor_rr_arbiter;

    localparam int WIDTH = 11;
    localparam int NREQ  = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       grant;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_id;
    logic                  out_ready;
`ifdef XOR_ARB_PARITY_EN
    logic                  out_parity;
`endif

    int passed = 0;
    int total  = 0;
    bit run    = 1'b0;

    xor_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
`ifdef XOR_ARB_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: holds the result slot and rotating priority as plain ints.
    int          m_ptr   = 0;
    bit          m_valid = 0;
    int          m_data  = 0;
    int          m_id    = 0;
    int          m_par   = 0;

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic int model_grant();
        int w;
        if (reset) return 0;
        if (m_valid && !out_ready) return 0;
        w = model_winner();
        if (w < 0) return 0;
        return 1 << w;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_par = 0;
        end else if (!m_valid || out_ready) begin
            w = model_winner();
            if (w >= 0) begin
                m_data  = int'(a_bus[w*WIDTH +: WIDTH] ^ b_bus[w*WIDTH +: WIDTH]);
                m_par   = $countones(m_data) % 2;
                m_id    = w;
                m_valid = 1;
                m_ptr   = (w + 1) % NREQ;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("m_grant", 32'(grant), 32'(model_grant()));
            chk("m_valid", 32'(out_valid), 32'(m_valid));
            chk("m_data", 32'(out_data), 32'(m_data));
            chk("m_id", 32'(out_id), 32'(m_id));
`ifdef XOR_ARB_PARITY_EN
            chk("m_parity", 32'(out_parity), 32'(m_par));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ab(input int i, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
        a_bus[i*WIDTH +: WIDTH] = a;
        b_bus[i*WIDTH +: WIDTH] = b;
    endtask

    initial begin
        reset     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        a_bus     = '0;
        b_bus     = '0;
        set_ab(0, 11'h123, 11'h0F0);
        set_ab(1, 11'h456, 11'h3C3);
        set_ab(2, 11'h789, 11'h555);
        set_ab(3, 11'h7AB, 11'h00F);

        step(); run = 1'b1; #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        step(); #2;
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);

        step(); reset = 1'b0; #2;
        chk("rr_g0", 32'(grant), 32'h1);
        step(); #2;
        chk("rr_g1", 32'(grant), 32'h2);
        chk("rr_id0", 32'(out_id), 32'h0);
        chk("rr_data0", 32'(out_data), 32'h1D3);
        step(); #2;
        chk("rr_g2", 32'(grant), 32'h4);
        chk("rr_id1", 32'(out_id), 32'h1);
        step(); #2;
        chk("rr_g3", 32'(grant), 32'h8);
        chk("rr_id2", 32'(out_id), 32'h2);
        step(); #2;
        chk("rr_g4", 32'(grant), 32'h1);
        chk("rr_id3", 32'(out_id), 32'h3);

        step(); req = 4'b0100; set_ab(2, 11'h7FF, 11'h555); #2;
        chk("single_grant", 32'(grant), 32'h4);
        step(); req = 4'b0010; #2;
        chk("single_data", 32'(out_data), 32'h2AA);
        chk("single_id", 32'(out_id), 32'h2);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("wrap_grant", 32'(grant), 32'h2);
        step(); req = 4'b0000; #2;
        chk("wrap_id", 32'(out_id), 32'h1);
        chk("idle_grant", 32'(grant), 32'h0);
        step(); req = 4'b1111; #2;
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("ptr2_grant", 32'(grant), 32'h4);

        step(); out_ready = 1'b0; req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("bp_grant", 32'(grant), 32'h0);
            chk("bp_id", 32'(out_id), 32'h2);
            chk("bp_valid", 32'(out_valid), 32'h1);
            step();
        end
        out_ready = 1'b1; #2;
        chk("bp_release", 32'(grant), 32'h1);
        step(); req = 4'b0000; #2;
        chk("bp_next_id", 32'(out_id), 32'h0);

        step(); req = 4'b0001; set_ab(0, 11'h003, 11'h000); #2;
        chk("par_g0", 32'(grant), 32'h1);
        step(); set_ab(0, 11'h001, 11'h000); #2;
        chk("par_data3", 32'(out_data), 32'h003);
`ifdef XOR_ARB_PARITY_EN
        chk("par_even", 32'(out_parity), 32'h0);
`endif
        step(); req = 4'b0000; out_ready = 1'b0; #2;
        chk("par_data1", 32'(out_data), 32'h001);
`ifdef XOR_ARB_PARITY_EN
        chk("par_odd", 32'(out_parity), 32'h1);
`endif
        step(); reset = 1'b1; req = 4'b1111; #2;
        chk("midrst_grant", 32'(grant), 32'h0);
        step(); reset = 1'b0; out_ready = 1'b1; #2;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_grant0", 32'(grant), 32'h1);
`ifdef XOR_ARB_PARITY_EN
        chk("midrst_parity", 32'(out_parity), 32'h0);
`endif
        step(); req = 4'b0000;
        step();
        step();
        run = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
